cluster_unpacker768: RTL and testbench

//  Inverse of the 768-pad cluster priority encoder. Accepts the cluster stream one word per clock:
//  11-bit pad address, 3-bit count (size-1), valid. Rebuilds the per-frame 768-pad hit map.

---
 rtl/cluster_unpacker768_if.sv | 8 +
 rtl/cluster_unpacker768.sv | 92 +++++++++
 tb/tb_cluster_unpacker768.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/cluster_unpacker768_if.sv
// cluster_unpacker768_if: cluster word stream, one word per clock
interface cluster_unpacker768_if;
  logic        cluster_vld;
  logic [10:0] cluster_adr;
  logic [2:0]  cluster_cnt;
  modport master (output cluster_vld, cluster_adr, cluster_cnt);
  modport slave  (input  cluster_vld, cluster_adr, cluster_cnt);
endinterface

// File: rtl/cluster_unpacker768.sv
// cluster_unpacker768: rebuilds the per-frame pad hit map from a cluster word stream
module cluster_unpacker768 #(
  parameter int MXPADS      = 768,
  parameter int MXCLUSTERS  = 16,
  parameter int INVALID_ADR = 2047
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    frame_clock,
  cluster_unpacker768_if.slave    cl,
  output logic [MXPADS-1:0]       hits_out,
  output logic [MXPADS-1:0]       vpfs_out,
  output logic [3*MXPADS-1:0]     cnts_out,
  output logic                    frame_vld,
  output logic [4:0]              n_clusters,
  output logic                    overflow,
  output logic                    adr_err
);
  localparam int CW = 3*MXPADS;
  typedef enum logic {ACCUM, FLUSH} state_t;
  state_t            state;
  logic [1:0]        fc_sr;
  logic [MXPADS-1:0] acc_hits, acc_vpfs, w_hits, w_vpfs;
  logic [CW-1:0]     acc_cnts, w_cnts, cnts_clr;
  logic [4:0]        cnt_q;
  logic              acc_ovf, acc_adr_err;
  logic              boundary, in_range, take, bad, full_hit;
  logic [7:0]        run;
  logic [12:0]       adr3;
  always_comb begin
    boundary = fc_sr == 2'b01;
    in_range = cl.cluster_adr < 11'(MXPADS);
    take     = cl.cluster_vld && in_range && (state == FLUSH || cnt_q != 5'(MXCLUSTERS));
    bad      = cl.cluster_vld && !in_range && cl.cluster_adr != 11'(INVALID_ADR);
    full_hit = cl.cluster_vld && in_range && state == ACCUM && cnt_q == 5'(MXCLUSTERS);
    run      = 8'hff >> (3'd7 - cl.cluster_cnt);
    adr3     = 13'(cl.cluster_adr) * 13'd3;
    // shifting past the top pad drops the bits, which is the required clipping
    w_hits   = MXPADS'(run) << cl.cluster_adr;
    w_vpfs   = MXPADS'(1) << cl.cluster_adr;
    w_cnts   = CW'(cl.cluster_cnt) << adr3;
    cnts_clr = ~(CW'(3'b111) << adr3);
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ACCUM;
      fc_sr       <= 2'b11;
      acc_hits    <= '0;
      acc_vpfs    <= '0;
      acc_cnts    <= '0;
      cnt_q       <= '0;
      acc_ovf     <= 1'b0;
      acc_adr_err <= 1'b0;
      hits_out    <= '0;
      vpfs_out    <= '0;
      cnts_out    <= '0;
      frame_vld   <= 1'b0;
      n_clusters  <= '0;
      overflow    <= 1'b0;
      adr_err     <= 1'b0;
    end else begin
      fc_sr     <= {fc_sr[0], frame_clock};
      frame_vld <= 1'b0;
      if (state == FLUSH) begin
        state       <= ACCUM;
        frame_vld   <= 1'b1;
        hits_out    <= acc_hits;
        vpfs_out    <= acc_vpfs;
        cnts_out    <= acc_cnts;
        n_clusters  <= cnt_q;
        overflow    <= acc_ovf;
        adr_err     <= acc_adr_err;
        acc_hits    <= take ? w_hits : '0;
        acc_vpfs    <= take ? w_vpfs : '0;
        acc_cnts    <= take ? w_cnts : '0;
        cnt_q       <= 5'(take);
        acc_ovf     <= 1'b0;
        acc_adr_err <= bad;
      end else begin
        if (boundary) state <= FLUSH;
        if (take) begin
          acc_hits <= acc_hits | w_hits;
          acc_vpfs <= acc_vpfs | w_vpfs;
          acc_cnts <= (acc_cnts & cnts_clr) | w_cnts;
          cnt_q    <= cnt_q + 5'd1;
        end
        if (bad) acc_adr_err <= 1'b1;
        if (full_hit) acc_ovf <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_cluster_unpacker768.sv
// tb_cluster_unpacker768: directed checks of frame rebuild, clipping, overflow, address errors and reset
module tb_cluster_unpacker768;
  logic         clock = 1'b0;
  logic         reset_n = 1'b0;
  logic         frame_clock = 1'b0;
  logic [767:0] hits_out, vpfs_out;
  logic [2303:0] cnts_out;
  logic         frame_vld, overflow, adr_err;
  logic [4:0]   n_clusters;
  int vectors = 0;
  int miscompares = 0;
  cluster_unpacker768_if bus ();
  cluster_unpacker768 dut (
    .clock(clock), .reset_n(reset_n), .frame_clock(frame_clock), .cl(bus),
    .hits_out(hits_out), .vpfs_out(vpfs_out), .cnts_out(cnts_out), .frame_vld(frame_vld),
    .n_clusters(n_clusters), .overflow(overflow), .adr_err(adr_err)
  );
  always #5 clock = ~clock;
  task automatic check(input string tag, input logic [2303:0] obs, input logic [2303:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic cyc(input logic v, input logic [10:0] a, input logic [2:0] c, input logic f);
    bus.cluster_vld = v;
    bus.cluster_adr = a;
    bus.cluster_cnt = c;
    frame_clock = f;
    @(negedge clock);
  endtask
  task automatic end_frame();
    cyc(1'b0, 11'd0, 3'd0, 1'b1);
    cyc(1'b0, 11'd0, 3'd0, 1'b0);
    cyc(1'b0, 11'd0, 3'd0, 1'b0);
  endtask
  task automatic chk_frame(input string tag, input logic [767:0] eh, input logic [767:0] ev,
                           input logic [2303:0] ec, input logic [4:0] en, input logic eo, input logic ee);
    check({tag, ".frame_vld"}, 2304'(frame_vld), 2304'(1'b1));
    check({tag, ".hits"}, 2304'(hits_out), 2304'(eh));
    check({tag, ".vpfs"}, 2304'(vpfs_out), 2304'(ev));
    check({tag, ".cnts"}, cnts_out, ec);
    check({tag, ".n"}, 2304'(n_clusters), 2304'(en));
    check({tag, ".ovf"}, 2304'(overflow), 2304'(eo));
    check({tag, ".adr_err"}, 2304'(adr_err), 2304'(ee));
  endtask
  task automatic chk_zero(input string tag);
    check({tag, ".hits"}, 2304'(hits_out), '0);
    check({tag, ".vpfs"}, 2304'(vpfs_out), '0);
    check({tag, ".cnts"}, cnts_out, '0);
    check({tag, ".flags"}, 2304'({frame_vld, n_clusters, overflow, adr_err}), '0);
  endtask
  initial begin
    logic [767:0]  eh, ev, map;
    logic [2303:0] ec;
    int adrs[$];
    int lens[$];
    bus.cluster_vld = 1'b0;
    bus.cluster_adr = '0;
    bus.cluster_cnt = '0;
    @(negedge clock);
    @(negedge clock);
    chk_zero("reset");
    reset_n = 1'b1;
    // single 3-pad cluster at pad 5
    cyc(1'b1, 11'd5, 3'd2, 1'b0);
    end_frame();
    chk_frame("t1", 768'b111 << 5, 768'b1 << 5, 2304'd2 << 15, 5'd1, 1'b0, 1'b0);
    cyc(1'b0, 11'd0, 3'd0, 1'b0);
    check("t1.strobe_drop", 2304'(frame_vld), '0);
    check("t1.hold", 2304'(hits_out), 2304'(768'b111 << 5));
    // 8-pad cluster at 766 clips at the top, no wrap
    cyc(1'b1, 11'd766, 3'd7, 1'b0);
    end_frame();
    chk_frame("t2", 768'b11 << 766, 768'b1 << 766, 2304'd7 << 2298, 5'd1, 1'b0, 1'b0);
    // 20 words, only the first 16 land
    eh = '0;
    for (int i = 0; i < 20; i++) begin
      if (i < 16) eh[40*i] = 1'b1;
      cyc(1'b1, 11'(40*i), 3'd0, 1'b0);
    end
    end_frame();
    chk_frame("t3", eh, eh, '0, 5'd16, 1'b1, 1'b0);
    // invalid address ignored silently, out-of-range flagged
    cyc(1'b1, 11'd2047, 3'd3, 1'b0);
    cyc(1'b1, 11'd900, 3'd0, 1'b0);
    end_frame();
    chk_frame("t4", '0, '0, '0, 5'd0, 1'b0, 1'b1);
    // word in boundary cycle goes to old frame, word in flush to new frame
    cyc(1'b0, 11'd0, 3'd0, 1'b1);
    cyc(1'b1, 11'd10, 3'd0, 1'b0);
    cyc(1'b1, 11'd20, 3'd0, 1'b0);
    chk_frame("t5a", 768'b1 << 10, 768'b1 << 10, '0, 5'd1, 1'b0, 1'b0);
    cyc(1'b0, 11'd0, 3'd0, 1'b0);
    end_frame();
    chk_frame("t5b", 768'b1 << 20, 768'b1 << 20, '0, 5'd1, 1'b0, 1'b0);
    // repeated address: hits OR, last count wins
    cyc(1'b1, 11'd50, 3'd4, 1'b0);
    cyc(1'b1, 11'd50, 3'd1, 1'b0);
    end_frame();
    chk_frame("rep", 768'b11111 << 50, 768'b1 << 50, 2304'd1 << 150, 5'd2, 1'b0, 1'b0);
    // loopback through a bench-side priority encoder
    for (int r = 0; r < 3; r++) begin
      map = '0;
      for (int k = 0; k < 5; k++) begin
        int a, l;
        a = $urandom_range(0, 767);
        l = $urandom_range(1, 8);
        for (int i = 0; i < l; i++) if (a + i < 768) map[a+i] = 1'b1;
      end
      adrs.delete();
      lens.delete();
      for (int p = 0; p < 768;) begin
        if (map[p]) begin
          int len;
          len = 0;
          while (p + len < 768 && len < 8 && map[p+len]) len++;
          adrs.push_back(p);
          lens.push_back(len);
          p += len;
        end else p++;
      end
      ev = '0;
      ec = '0;
      foreach (adrs[i]) begin
        ev[adrs[i]] = 1'b1;
        ec[3*adrs[i] +: 3] = 3'(lens[i] - 1);
        cyc(1'b1, 11'(adrs[i]), 3'(lens[i] - 1), 1'b0);
      end
      end_frame();
      chk_frame("loop", map, ev, ec, 5'(adrs.size()), 1'b0, 1'b0);
    end
    // reset mid-frame discards the partial frame
    cyc(1'b1, 11'd300, 3'd2, 1'b0);
    reset_n = 1'b0;
    #1;
    chk_zero("midrst");
    cyc(1'b0, 11'd0, 3'd0, 1'b0);
    reset_n = 1'b1;
    cyc(1'b1, 11'd100, 3'd1, 1'b0);
    check("midrst.no_strobe", 2304'(frame_vld), '0);
    end_frame();
    chk_frame("post", 768'b11 << 100, 768'b1 << 100, 2304'd1 << 300, 5'd1, 1'b0, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
